// File: rtl/branch_update_ctrl_pkg.sv
// rtl/branch_update_ctrl_pkg.sv - shared widths, FSM states and D/E record for branch_update_ctrl
package branch_update_ctrl_pkg;

   localparam int IDX_W_DEFAULT = 6;
   localparam int PC_W_DEFAULT  = 32;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_RECOVER = 1'b1
   } state_t;

   // Record widths follow the package defaults shared with the table ports
   typedef struct packed {
      logic                      valid;
      logic                      pred;
      logic [IDX_W_DEFAULT-1:0]  idx;
      logic [PC_W_DEFAULT-1:0]   target;
      logic [PC_W_DEFAULT-1:0]   pcPlus4;
   } de_rec_t;

endpackage

// File: rtl/branch_update_ctrl_sat_counter.sv
// rtl/branch_update_ctrl_sat_counter.sv - saturating event counter (sat_counter)
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/branch_update_ctrl.sv
// rtl/branch_update_ctrl.sv - resolves 1-bit branch predictions, updates the table, drives flush/redirect
module branch_update_ctrl
   import branch_update_ctrl_pkg::*;
#(
   parameter int IDX_W        = IDX_W_DEFAULT,
   parameter int PC_W         = PC_W_DEFAULT,
   parameter int FLUSH_CYCLES = 2,
   parameter bit WRITE_ALWAYS = 1'b0,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             branchD,
   input  logic [IDX_W-1:0] addrD,
   input  logic             predD,
   input  logic [PC_W-1:0]  targetD,
   input  logic [PC_W-1:0]  pcPlus4D,
   input  logic             takenE,
   output logic             predEffD,
   output logic             we,
   output logic             wd,
   output logic [IDX_W-1:0] addrE,
   output logic             mispredictE,
   output logic             redirectValid,
   output logic [PC_W-1:0]  redirectPC,
   output logic             flush,
   output logic [CNT_W-1:0] brCount,
   output logic [CNT_W-1:0] missCount
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

   de_rec_t         de_q;
   state_t          state_q, state_d;
   logic [FC_W-1:0] fc_q, fc_d;
   logic            res;
   logic            do_write;

   // The table only sees a write one edge after we rises, so forward it here
   assign predEffD = (we && (addrE == addrD)) ? wd : predD;

   assign res         = de_q.valid & ~stall;
   assign mispredictE = res & (takenE != de_q.pred);
   assign do_write    = res & (WRITE_ALWAYS | mispredictE);

   assign redirectValid = mispredictE;
   assign redirectPC    = mispredictE ? (takenE ? de_q.target : de_q.pcPlus4) : '0;
   assign flush         = mispredictE | (state_q == ST_RECOVER);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         de_q <= '0;
      end else if (flush) begin
         de_q.valid <= 1'b0;
      end else if (!stall) begin
         de_q <= '{valid: branchD, pred: predEffD, idx: addrD,
                   target: targetD, pcPlus4: pcPlus4D};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we    <= 1'b0;
         wd    <= 1'b0;
         addrE <= '0;
      end else begin
         we <= do_write;
         if (do_write) begin
            wd    <= takenE;
            addrE <= de_q.idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         fc_q    <= '0;
      end else begin
         state_q <= state_d;
         fc_q    <= fc_d;
      end
   end

   // fc counts the flush cycles still owed after the current one
   always_comb begin
      state_d = state_q;
      fc_d    = fc_q;
      case (state_q)
         ST_IDLE: begin
            if (mispredictE && (FLUSH_CYCLES > 1)) begin
               state_d = ST_RECOVER;
               fc_d    = FC_RELOAD;
            end
         end
         ST_RECOVER: begin
            if (mispredictE) begin
               fc_d = FC_RELOAD;
            end else if (!stall) begin
               if (fc_q <= FC_W'(1)) begin
                  state_d = ST_IDLE;
               end else begin
                  fc_d = fc_q - FC_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   sat_counter #(.W(CNT_W)) u_br_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (res),
      .count (brCount)
   );

   sat_counter #(.W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (mispredictE),
      .count (missCount)
   );

endmodule

// File: tb/tb_branch_update_ctrl.sv
// tb/tb_branch_update_ctrl.sv - scoreboard bench for branch_update_ctrl against a table/pipeline model
module tb_branch_update_ctrl;

   localparam int CNT_W   = 4;
   localparam int FLUSH_N = 2;
   localparam bit WA      = 1'b0;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, branchD, predD, takenE;
   logic [5:0]  addrD;
   logic [31:0] targetD, pcPlus4D;
   logic        predEffD, we, wd, mispredictE, redirectValid, flush;
   logic [5:0]  addrE;
   logic [31:0] redirectPC;
   logic [CNT_W-1:0] brCount, missCount;

   branch_update_ctrl #(
      .IDX_W(6), .PC_W(32), .FLUSH_CYCLES(FLUSH_N), .WRITE_ALWAYS(WA), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .stall(stall), .branchD(branchD), .addrD(addrD),
      .predD(predD), .targetD(targetD), .pcPlus4D(pcPlus4D), .takenE(takenE),
      .predEffD(predEffD), .we(we), .wd(wd), .addrE(addrE), .mispredictE(mispredictE),
      .redirectValid(redirectValid), .redirectPC(redirectPC), .flush(flush),
      .brCount(brCount), .missCount(missCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pe, mis, rv, fl, we, wd;
      logic [5:0]  addr;
      logic [31:0] rpc;
      int          br, miss;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Model: the prediction table itself, one in-flight branch slot, the pending write, owed flush cycles
   logic        tbl [64];
   logic        m_valid, m_pred, m_we, m_wd;
   logic [5:0]  m_idx, m_addr;
   logic [31:0] m_target, m_pc4;
   int          m_rem, m_br, m_miss;

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_valid = 0; m_pred = 0; m_we = 0; m_wd = 0; m_idx = 0; m_addr = 0;
      m_target = 0; m_pc4 = 0; m_rem = 0; m_br = 0; m_miss = 0;
   endtask

   task automatic cyc(input logic b, input logic [5:0] a, input logic [31:0] t,
                      input logic [31:0] p, input logic tk, input logic st);
      exp_t e;
      logic pd, res, mis;
      @(posedge clk); #1;
      pd = tbl[a];
      branchD = b; addrD = a; predD = pd; targetD = t; pcPlus4D = p;
      takenE = tk; stall = st;
      res = m_valid && !st;
      mis = res && (tk != m_pred);
      e.pe   = (m_we && m_addr == a) ? m_wd : pd;
      e.mis  = mis;
      e.rv   = mis;
      e.rpc  = mis ? (tk ? m_target : m_pc4) : 32'h0;
      e.fl   = mis || (m_rem > 0);
      e.we   = m_we;
      e.wd   = m_wd;
      e.addr = m_addr;
      e.br   = sat(m_br);
      e.miss = sat(m_miss);
      exp_q.push_back(e);
      if (m_we) tbl[m_addr] = m_wd;
      if (res && (WA || mis)) begin
         m_we = 1; m_wd = tk; m_addr = m_idx;
      end else begin
         m_we = 0;
      end
      if (e.fl) m_valid = 0;
      else if (!st) begin
         m_valid = b; m_pred = e.pe; m_idx = a; m_target = t; m_pc4 = p;
      end
      if (mis) m_rem = FLUSH_N - 1;
      else if (m_rem > 0 && !st) m_rem--;
      m_br   += int'(res);
      m_miss += int'(mis);
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      reset = 1; branchD = 0; predD = 0;
      #1;
      chk("rst_we", 32'(we), 0);
      chk("rst_wd", 32'(wd), 0);
      chk("rst_addrE", 32'(addrE), 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_redirectValid", 32'(redirectValid), 0);
      chk("rst_redirectPC", redirectPC, 0);
      chk("rst_predEffD", 32'(predEffD), 0);
      chk("rst_mispredictE", 32'(mispredictE), 0);
      chk("rst_brCount", 32'(brCount), 0);
      chk("rst_missCount", 32'(missCount), 0);
      model_clear();
      @(posedge clk); #1;
      reset = 0;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("predEffD", 32'(predEffD), 32'(e.pe));
         chk("mispredictE", 32'(mispredictE), 32'(e.mis));
         chk("redirectValid", 32'(redirectValid), 32'(e.rv));
         chk("redirectPC", redirectPC, e.rpc);
         chk("flush", 32'(flush), 32'(e.fl));
         chk("we", 32'(we), 32'(e.we));
         chk("wd", 32'(wd), 32'(e.wd));
         chk("addrE", 32'(addrE), 32'(e.addr));
         chk("brCount", 32'(brCount), 32'(e.br));
         chk("missCount", 32'(missCount), 32'(e.miss));
      end
   end

   initial begin
      int stall_left;
      logic [5:0] a;
      reset = 1; stall = 0; branchD = 0; addrD = 0; predD = 0; takenE = 0;
      targetD = 0; pcPlus4D = 0;
      for (int i = 0; i < 64; i++) tbl[i] = 1'($urandom);
      model_clear();
      repeat (2) @(posedge clk);
      #1 reset = 0;
      do_reset();

      // correct prediction at index 5
      tbl[5] = 1'b1;
      cyc(1, 6'd5, 32'h200, 32'h20, 1'b0, 1'b0);
      cyc(0, 6'd0, 32'h0, 32'h0, 1'b1, 1'b0);
      cyc(0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0);

      // mispredict at index 9, then bypass hit (addr 9) and miss (addr 10)
      tbl[9] = 1'b0; tbl[10] = 1'b0;
      cyc(1, 6'd9, 32'h100, 32'h44, 1'b0, 1'b0);
      cyc(0, 6'd3, 32'h0, 32'h0, 1'b1, 1'b0);
      cyc(1, 6'd9, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc(1, 6'd10, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc(0, 6'd9, 32'h0, 32'h0, 1'b0, 1'b0);

      // branch held in E by a 3-cycle stall, then released as a mispredict
      cyc(1, 6'd12, 32'h300, 32'h30, 1'b0, 1'b0);
      cyc(0, 6'd0, 32'h0, 32'h0, ~m_pred, 1'b1);
      cyc(0, 6'd0, 32'h0, 32'h0, m_pred, 1'b1);
      cyc(0, 6'd0, 32'h0, 32'h0, ~m_pred, 1'b1);
      cyc(0, 6'd0, 32'h0, 32'h0, ~m_pred, 1'b0);
      // stall while recovering: flush must stretch
      cyc(0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b1);
      cyc(0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b1);
      cyc(0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      cyc(0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0);

      // mispredict then reset during recovery with a write pending
      cyc(1, 6'd20, 32'h400, 32'h50, 1'b0, 1'b0);
      cyc(0, 6'd0, 32'h0, 32'h0, ~m_pred, 1'b0);
      do_reset();

      stall_left = 0;
      for (int n = 0; n < 700; n++) begin
         logic st;
         if (stall_left > 0) begin
            st = 1; stall_left--;
         end else if ($urandom_range(0, 9) == 0) begin
            st = 1; stall_left = $urandom_range(0, 3);
         end else begin
            st = 0;
         end
         a = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
         cyc(1'($urandom_range(0, 9) < 6), a, $urandom, $urandom, 1'($urandom), st);
         if (m_rem > 0 && $urandom_range(0, 39) == 0) do_reset();
      end

      // drive guaranteed mispredicts until both counters pin at all-ones
      for (int n = 0; n < 20; n++) begin
         cyc(1, 6'($urandom), $urandom, $urandom, 1'b0, 1'b0);
         cyc(0, 6'd0, 32'h0, 32'h0, ~m_pred, 1'b0);
         cyc(0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      end
      repeat (2) @(posedge clk);
      #6;
      chk("sat_missCount", 32'(missCount), 32'(CMAX));
      chk("sat_brCount", 32'(brCount), 32'(CMAX));
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
